// File: rtl/fp_mul_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fp_mul_pipe_pkg                                                |
// | Brief   : Shared constants, stage payload structs and the operand        |
// |           unpack/classify helper for the fp_mul_pipe multiplier.         |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package fp_mul_pipe_pkg;

    localparam int          c_exp_w   = 8;
    localparam int          c_man_w   = 23;
    localparam logic [9:0]  c_bias    = 10'd127;
    localparam logic [7:0]  c_exp_max = 8'hFF;
    localparam logic [31:0] c_qnan    = 32'h7FC0_0000;

    // Stage 1 payload: unpacked operands plus the already-resolved special
    // result, so later stages only carry it along.
    typedef struct packed {
        logic                      sign;
        logic signed [9:0]         exp;
        logic [c_man_w:0]          man_a;
        logic [c_man_w:0]          man_b;
        logic                      special;
        logic [31:0]               special_val;
        logic                      invalid;
    } s1_t;

    // Stage 2 payload: raw 48-bit significand product.
    typedef struct packed {
        logic                      sign;
        logic signed [9:0]         exp;
        logic [2*c_man_w+1:0]      prod;
        logic                      special;
        logic [31:0]               special_val;
        logic                      invalid;
    } s2_t;

    // Unpack both operands. A zero exponent field is treated as zero, so
    // denormal inputs are flushed here and never reach the multiplier.
    function automatic s1_t fp_unpack(input logic [31:0] a, input logic [31:0] b);
        s1_t  r;
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        a_zero = (a[30:23] == '0);
        b_zero = (b[30:23] == '0);
        a_inf  = (a[30:23] == c_exp_max) && (a[22:0] == '0);
        b_inf  = (b[30:23] == c_exp_max) && (b[22:0] == '0);
        a_nan  = (a[30:23] == c_exp_max) && (a[22:0] != '0);
        b_nan  = (b[30:23] == c_exp_max) && (b[22:0] != '0);

        r.sign    = a[31] ^ b[31];
        r.exp     = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
                    - $signed(c_bias);
        r.man_a   = {1'b1, a[22:0]};
        r.man_b   = {1'b1, b[22:0]};
        r.invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        r.special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        if (r.invalid)
            r.special_val = c_qnan;
        else if (a_inf | b_inf)
            r.special_val = {r.sign, c_exp_max, {c_man_w{1'b0}}};
        else
            r.special_val = {r.sign, {(c_exp_w + c_man_w){1'b0}}};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fp_mul_round                                                   |
// | Brief   : Combinational normalize, round-to-nearest-even, overflow /     |
// |           underflow clamp and pack of a 48-bit significand product.      |
// | Ports   : i_sign, i_exp (biased, 10-bit signed), i_prod (48-bit)         |
// |           o_result (packed single), o_overflow, o_underflow, o_inexact   |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fp_mul_round
    import fp_mul_pipe_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [47:0]       i_prod,
    output logic [31:0]       o_result,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_inexact
);

    logic signed [9:0] w_exp_norm;
    logic signed [9:0] w_exp_rnd;
    logic [22:0]       w_man;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [23:0]       w_man_rnd;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4): bit 47 set means
        // the value is >= 2 and needs one extra exponent step.
        if (i_prod[47]) begin
            w_man      = i_prod[46:24];
            w_guard    = i_prod[23];
            w_sticky   = |i_prod[22:0];
            w_exp_norm = i_exp + 10'sd1;
        end else begin
            w_man      = i_prod[45:23];
            w_guard    = i_prod[22];
            w_sticky   = |i_prod[21:0];
            w_exp_norm = i_exp;
        end

        w_round_up = w_guard & (w_sticky | w_man[0]);
        w_man_rnd  = {1'b0, w_man} + {23'd0, w_round_up};
        // Carry-out leaves w_man_rnd[22:0] at zero, i.e. significand 1.0.
        w_exp_rnd  = w_man_rnd[23] ? (w_exp_norm + 10'sd1) : w_exp_norm;

        o_overflow  = (w_exp_rnd >= 10'sd255);
        o_underflow = (w_exp_rnd <= 10'sd0);
        o_inexact   = (w_guard | w_sticky) & ~o_overflow & ~o_underflow;

        if (o_overflow)
            o_result = {i_sign, c_exp_max, {c_man_w{1'b0}}};
        else if (o_underflow)
            o_result = {i_sign, 31'h0};
        else
            o_result = {i_sign, w_exp_rnd[7:0], w_man_rnd[22:0]};
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fp_mul_pipe                                                    |
// | Brief   : Pipelined IEEE-754 single-precision multiplier with            |
// |           valid/ready flow control, one product per cycle.               |
// | Params  : PIPE_MUL - 1: register after the significand multiply          |
// |                      (latency 3); 0: latency 2                           |
// | Ports   : clock, reset (sync, active-high)                               |
// |           in_valid/in_ready, A_FP, B_FP   - operand side                 |
// |           out_valid/out_ready, P_FP       - product side                 |
// |           flags {invalid,overflow,underflow,inexact}                     |
// |                  - present only with `define FP_MUL_FLAGS_EN             |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fp_mul_pipe
    import fp_mul_pipe_pkg::*;
#(
    parameter int PIPE_MUL = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A_FP,
    input  logic [31:0] B_FP,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] P_FP
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    logic        w_en;
    logic        r_s1_valid;
    s1_t         r_s1;
    s2_t         w_s2_next;
    s2_t         w_s3;
    logic        w_s3_valid;
    logic [31:0] w_rnd_result;
    logic        w_rnd_ovf;
    logic        w_rnd_unf;
    logic        w_rnd_inx;
    logic [31:0] w_p_next;
    logic [3:0]  w_flags_next;
    logic        r_out_valid;
    logic [31:0] r_p;

    // Whole pipe moves in lockstep; a stalled output freezes every stage,
    // so bubbles stay where they are.
    assign w_en      = ~r_out_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign P_FP      = r_p;

    // Stage 1: unpack / classify
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            if (in_valid)
                r_s1 <= fp_unpack(A_FP, B_FP);
        end
    end

    // Stage 2: significand multiply
    always_comb begin
        w_s2_next.sign        = r_s1.sign;
        w_s2_next.exp         = r_s1.exp;
        w_s2_next.prod        = 48'(r_s1.man_a) * 48'(r_s1.man_b);
        w_s2_next.special     = r_s1.special;
        w_s2_next.special_val = r_s1.special_val;
        w_s2_next.invalid     = r_s1.invalid;
    end

    if (PIPE_MUL != 0) begin : g_pipe_mul
        logic r_s2_valid;
        s2_t  r_s2;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_s2_valid <= 1'b0;
            end else if (w_en) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid)
                    r_s2 <= w_s2_next;
            end
        end

        assign w_s3_valid = r_s2_valid;
        assign w_s3       = r_s2;
    end else begin : g_comb_mul
        assign w_s3_valid = r_s1_valid;
        assign w_s3       = w_s2_next;
    end

    // Stage 3: normalize / round / pack
    fp_mul_round u_round (
        .i_sign      (w_s3.sign),
        .i_exp       (w_s3.exp),
        .i_prod      (w_s3.prod),
        .o_result    (w_rnd_result),
        .o_overflow  (w_rnd_ovf),
        .o_underflow (w_rnd_unf),
        .o_inexact   (w_rnd_inx)
    );

    // Special operands override whatever the arithmetic path produced.
    assign w_p_next     = w_s3.special ? w_s3.special_val : w_rnd_result;
    assign w_flags_next = w_s3.special ? {w_s3.invalid, 3'b000}
                                       : {1'b0, w_rnd_ovf, w_rnd_unf, w_rnd_inx};

    // P_FP only updates with a new valid result, so it holds otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_p         <= 32'h0;
        end else if (w_en) begin
            r_out_valid <= w_s3_valid;
            if (w_s3_valid)
                r_p <= w_p_next;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] r_flags;

    always_ff @(posedge clock) begin
        if (reset)
            r_flags <= 4'h0;
        else if (w_en && w_s3_valid)
            r_flags <= w_flags_next;
    end

    assign flags = r_flags;
`else
    logic [3:0] w_unused_flags;
    assign w_unused_flags = w_flags_next;
`endif

endmodule
`default_nettype wire
